// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Receives a length-prefixed program image over a byte stream, writes it as
// little-endian 32-bit words starting at BASE_WORD, checks an XOR checksum
// and then releases the core's reset. A strap skips loading entirely.
module imem_loader #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_WORD = 14'h2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_skip,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Largest image (in words) that fits between BASE_WORD and the top of memory.
  localparam logic [32:0] MAX_WORDS_C =
    (33'd1 << ADDR_W) - {{(33-ADDR_W){1'b0}}, BASE_WORD};

  state_t              state_r;
  logic [1:0]          lane_r;
  logic [23:0]         byte_buf_r;
  logic [31:0]         len_r;
  logic [7:0]          csum_r;
  logic                run_r;

  logic                accept_s;
  logic [31:0]         hdr_len_s;
  logic                last_word_s;

  // Running checksum step: fold one data byte into the XOR accumulator.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    csum_update = acc ^ b;
  endfunction

  assign accept_s    = rx_valid & rx_ready;
  // Full header value as it would be once the current (4th) byte lands.
  assign hdr_len_s   = {rx_data, byte_buf_r};
  // The word being completed now is the final one of the image.
  assign last_word_s = (({{(31-ADDR_W){1'b0}}, word_cnt} + 32'd1) == len_r);
  // Core reset is held until the loader has committed to running.
  assign core_rst_n  = reset & run_r;

  // Byte acceptance is a pure decode of the loader state.
  always_comb begin
    rx_ready = 1'b0;
    case (state_r)
      ST_HDR, ST_DATA, ST_CSUM: rx_ready = 1'b1;
      default:                  rx_ready = 1'b0;
    endcase
  end

  // Loader state machine, byte assembly, memory write port and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_START;
      lane_r     <= 2'd0;
      byte_buf_r <= 24'd0;
      len_r      <= 32'd0;
      csum_r     <= 8'd0;
      run_r      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= {ADDR_W{1'b0}};
      imem_wdata <= 32'd0;
      word_cnt   <= {(ADDR_W+1){1'b0}};
    end else begin
      imem_we <= 1'b0;
      // Release lags entry into RUN by one edge so the last write settles first.
      run_r   <= (state_r == ST_RUN);
      done    <= (state_r == ST_RUN);

      // Lower three byte lanes are staged; the 4th completes the word in place.
      if (accept_s && (state_r == ST_HDR || state_r == ST_DATA)) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0:    byte_buf_r[7:0]   <= rx_data;
          2'd1:    byte_buf_r[15:8]  <= rx_data;
          2'd2:    byte_buf_r[23:16] <= rx_data;
          default: byte_buf_r        <= byte_buf_r;
        endcase
      end else begin
        lane_r <= lane_r;
      end

      case (state_r)
        ST_START: begin
          if (boot_skip) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (accept_s && lane_r == 2'd3) begin
            len_r <= hdr_len_s;
            if (hdr_len_s == 32'd0) begin
              state_r <= ST_CSUM;
            end else if ({1'b0, hdr_len_s} > MAX_WORDS_C) begin
              state_r <= ST_ERR;
              err     <= 1'b1;
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_HDR;
          end
        end

        ST_DATA: begin
          if (accept_s) begin
            csum_r <= csum_update(csum_r, rx_data);
            if (lane_r == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx_data, byte_buf_r};
              imem_waddr <= BASE_WORD + word_cnt[ADDR_W-1:0];
              word_cnt   <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
              if (last_word_s) begin
                state_r <= ST_CSUM;
              end else begin
                state_r <= ST_DATA;
              end
            end else begin
              state_r <= ST_DATA;
            end
          end else begin
            state_r <= ST_DATA;
          end
        end

        ST_CSUM: begin
          if (accept_s) begin
            if (rx_data == csum_r) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_ERR;
              err     <= 1'b1;
            end
          end else begin
            state_r <= ST_CSUM;
          end
        end

        ST_RUN: state_r <= ST_RUN;

        ST_ERR: state_r <= ST_ERR;

        default: begin
          // Unreachable encoding: fail safe with the core held in reset.
          state_r <= ST_ERR;
          err     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario-based self-checking bench for imem_loader.
module tb_imem_loader;
  localparam int                ADDR_W = 14;
  localparam logic [ADDR_W-1:0] BASE   = 14'h2000;

  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic              boot_skip = 1'b0;
  logic              rx_valid  = 1'b0;
  logic [7:0]        rx_data   = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_cnt    = 0;
  bit gap_en    = 1'b0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0]        img_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .BASE_WORD(BASE)) dut (
    .clk(clk), .reset(reset), .boot_skip(boot_skip),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .done(done), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Count every write strobe cycle so stray or stretched writes show up.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) wr_cnt++;
  end

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (img_q[i]) x = x ^ img_q[i][7:0] ^ img_q[i][15:8] ^ img_q[i][23:16] ^ img_q[i][31:24];
    return x;
  endfunction

  task automatic do_reset(input logic bs);
    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; boot_skip = bs;
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
  endtask

  // Offer one byte and return on the negedge after the edge that takes it.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gap_en) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_valid = 1'b1; rx_data = b;
    while (rx_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rx_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL byte_timeout: rx_ready=%b required 1", rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_header(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx);
    logic [ADDR_W+31:0] e;
    exp_q.push_back({BASE + idx[ADDR_W-1:0], w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    e = exp_q.pop_front();
    total_cnt++;
    if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, e})
      $display("FAIL write[%0d]: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
               idx, imem_we, imem_waddr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
    else pass_cnt++;
  endtask

  task automatic load_image(input logic [31:0] n, input logic [7:0] csum);
    send_header(n);
    foreach (img_q[i]) send_word(img_q[i], i);
    send_byte(csum);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err, word_cnt} !== '0)
      $display("FAIL reset_vals: rdy=%b we=%b addr=%h data=%h crst=%b done=%b err=%b cnt=%0d required all 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err, word_cnt);
    else pass_cnt++;
  endtask

  task automatic test_boot_skip();
    int w0;
    bit seen = 1'b0;
    do_reset(1'b1);
    w0 = wr_cnt;
    if (rx_ready === 1'b1) seen = 1'b1;
    @(negedge clk);
    if (rx_ready === 1'b1) seen = 1'b1;
    total_cnt++;
    if ({core_rst_n, done} !== 2'b00) $display("FAIL skip_edge1: crst=%b done=%b required 0 0", core_rst_n, done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({core_rst_n, done, err} !== 3'b110) $display("FAIL skip_edge2: crst=%b done=%b err=%b required 1 1 0", core_rst_n, done, err);
    else pass_cnt++;
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (8) begin @(negedge clk); if (rx_ready === 1'b1) seen = 1'b1; end
    rx_valid = 1'b0; boot_skip = 1'b0;
    total_cnt++;
    if (seen || wr_cnt != w0 || word_cnt !== '0)
      $display("FAIL skip_idle: rdy_seen=%b writes=%0d cnt=%0d required 0 0 0", seen, wr_cnt - w0, word_cnt);
    else pass_cnt++;
  endtask

  task automatic test_good_image();
    int w0;
    do_reset(1'b0);
    w0 = wr_cnt;
    img_q = '{32'h0000_0013, 32'h0000_006F};
    load_image(32'd2, 8'h7C);
    total_cnt++;
    if ({done, core_rst_n, rx_ready} !== 3'b000) $display("FAIL good_pre_release: done=%b crst=%b rdy=%b required 0 0 0", done, core_rst_n, rx_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, core_rst_n, err} !== 3'b110 || word_cnt !== 15'd2)
      $display("FAIL good_release: done=%b crst=%b err=%b cnt=%0d required 1 1 0 2", done, core_rst_n, err, word_cnt);
    else pass_cnt++;
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    total_cnt++;
    if (wr_cnt - w0 != 2 || rx_ready !== 1'b0)
      $display("FAIL good_after: writes=%0d rdy=%b required 2 0", wr_cnt - w0, rx_ready);
    else pass_cnt++;
  endtask

  task automatic test_bad_csum();
    int w0;
    do_reset(1'b0);
    w0 = wr_cnt;
    img_q = '{32'h0000_0013, 32'h0000_006F};
    load_image(32'd2, 8'h7D);
    total_cnt++;
    if ({err, core_rst_n, rx_ready} !== 3'b100) $display("FAIL bad_csum_err: err=%b crst=%b rdy=%b required 1 0 0", err, core_rst_n, rx_ready);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({err, core_rst_n, done, rx_ready} !== 4'b1000 || wr_cnt - w0 != 2)
      $display("FAIL bad_csum_hold: err=%b crst=%b done=%b rdy=%b writes=%0d required 1 0 0 0 2",
               err, core_rst_n, done, rx_ready, wr_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_too_long();
    int w0;
    do_reset(1'b0);
    w0 = wr_cnt;
    send_header(32'h0000_2001);
    total_cnt++;
    if ({err, rx_ready} !== 2'b10) $display("FAIL too_long_err: err=%b rdy=%b required 1 0", err, rx_ready);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (wr_cnt != w0 || word_cnt !== '0 || core_rst_n !== 1'b0)
      $display("FAIL too_long_quiet: writes=%0d cnt=%0d crst=%b required 0 0 0", wr_cnt - w0, word_cnt, core_rst_n);
    else pass_cnt++;
    do_reset(1'b0);
    send_header(32'h0000_2000);
    total_cnt++;
    if ({err, rx_ready} !== 2'b01) $display("FAIL max_len_ok: err=%b rdy=%b required 0 1", err, rx_ready);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    do_reset(1'b0);
    img_q.delete();
    load_image(32'd0, 8'h00);
    @(negedge clk);
    total_cnt++;
    if ({done, core_rst_n, err} !== 3'b110 || word_cnt !== '0)
      $display("FAIL zero_len: done=%b crst=%b err=%b cnt=%0d required 1 1 0 0", done, core_rst_n, err, word_cnt);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    int w0;
    do_reset(1'b0);
    w0 = wr_cnt;
    img_q = '{$urandom(), $urandom(), $urandom()};
    gap_en = 1'b1;
    load_image(32'd3, img_xor());
    gap_en = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({done, core_rst_n} !== 2'b11 || word_cnt !== 15'd3 || wr_cnt - w0 != 3)
      $display("FAIL gapped: done=%b crst=%b cnt=%0d writes=%0d required 1 1 3 3", done, core_rst_n, word_cnt, wr_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset(1'b0);
    send_header(32'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({rx_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err, word_cnt} !== '0)
      $display("FAIL mid_reset_vals: rdy=%b we=%b addr=%h data=%h crst=%b done=%b err=%b cnt=%0d required all 0",
               rx_ready, imem_we, imem_waddr, imem_wdata, core_rst_n, done, err, word_cnt);
    else pass_cnt++;
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    w0 = wr_cnt;
    img_q = '{32'h0000_0013, 32'h0000_006F};
    load_image(32'd2, 8'h7C);
    @(negedge clk);
    total_cnt++;
    if ({done, core_rst_n} !== 2'b11 || word_cnt !== 15'd2 || wr_cnt - w0 != 2)
      $display("FAIL reload: done=%b crst=%b cnt=%0d writes=%0d required 1 1 2 2", done, core_rst_n, word_cnt, wr_cnt - w0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_boot_skip();
    test_good_image();
    test_bad_csum();
    test_too_long();
    test_zero_len();
    test_gapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller that owns the instruction-memory write port and sequences the fetch stage out of reset. After reset it receives a program image as a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them into instruction memory starting at word `BASE_WORD`. It validates a trailing checksum, then releases the core's reset so fetch starts at byte address 0x8000. A strap input bypasses loading for images preloaded at elaboration.

## Interface
- `ADDR_W`, 14: instruction-memory word-address width; depth = 2^ADDR_W.
- `BASE_WORD`, 14'h2000: first word written; byte address 0x8000, the first PC fetched after core reset.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `boot_skip`  in  1  strap; sampled once, in the first cycle after reset deasserts.
- `rx_valid`  in  1  UART byte available.
- `rx_data`  in  8  UART byte.
- `rx_ready`  out  1  byte consumed when `rx_valid & rx_ready`.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_waddr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  assembled word.
- `core_rst_n`  out  1  active-low reset to fetch and the rest of the core; equals `reset & run_q`.
- `done`  out  1  image accepted, core running.
- `err`  out  1  sticky load error, core held in reset.
- `word_cnt`  out  ADDR_W+1  words written so far.

## Operation
- States: START, HDR, DATA, CSUM, RUN, ERR. Reset forces START.
- START, one cycle: if `boot_skip`=1, go to RUN; otherwise go to HDR.
- HDR: accept 4 bytes, LSB first, into length `N` (32 bits).
  - On the 4th byte: if `N`=0, go to CSUM.
  - If `N` > 2^ADDR_W − BASE_WORD, go to ERR.
  - Otherwise go to DATA.
- DATA:
  - Bytes fill a 2-bit lane counter, LSB first.
  - On the 4th lane, register the word and address `BASE_WORD + word_cnt`, pulse `imem_we`, and increment `word_cnt`.
  - After word `N` is written, go to CSUM.
- Checksum: an 8-bit running XOR of all DATA bytes; header bytes are excluded.
- CSUM: accept 1 byte. If it equals the XOR, go to RUN; otherwise go to ERR.
- RUN: `run_q`=1 and `done`=1. `rx_ready`=0, so further bytes are ignored. The state is terminal until reset.
- ERR: `err`=1 and `rx_ready`=0. `core_rst_n` stays 0. The state is terminal until reset.
- `rx_ready` is a combinational decode of the state: 1 in HDR, DATA and CSUM; 0 in START, RUN and ERR.
- `imem_waddr` arithmetic is modulo 2^ADDR_W. The header bound check guarantees no wrap past the top of memory.
- `word_cnt` is ADDR_W+1 bits wide and never overflows, because N ≤ 2^ADDR_W − BASE_WORD.

## Timing
- Reset values: state START; `rx_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `core_rst_n`=0, `done`=0, `err`=0, `word_cnt`=0; lane counter and XOR cleared.
- Reset asserted mid-load: everything returns to reset values immediately (asynchronous); partial words are discarded.
- Byte acceptance: at most one byte per cycle; `rx_valid` may be held high continuously.
- Write latency: `imem_we` is high in the cycle after the clock edge that accepts the 4th byte of a word, for exactly one cycle. `imem_waddr` and `imem_wdata` are valid in that same cycle and hold until the next write.
- Write-to-fetch hazard: the last write completes one cycle before the earliest possible `core_rst_n` rise.
- Release latency: `run_q`, `done` and `core_rst_n` rise on the edge after the matching checksum byte is accepted. Fetch's first edge out of reset then loads PC 0x7FFC; its next fetch address is 0x8000.
- `boot_skip` path: `core_rst_n` rises 2 edges after `reset` deasserts (START, then RUN).
- `err` rises on the edge that accepts the failing 4th header byte or the failing checksum byte.
- Gaps (`rx_valid`=0) may occur anywhere, including mid-word; state and lane counter hold.

## Test plan
- `boot_skip`=1 at reset release -> `rx_ready` never 1; `core_rst_n`=1 and `done`=1 at the 2nd edge; no `imem_we`.
- Header N=2, data bytes 13 00 00 00 6F 00 00 00, checksum 0x7C -> writes 0x00000013 at word 0x2000 and 0x0000006F at 0x2001; `done`=1 one cycle after the checksum byte; `word_cnt`=2.
- Same image with checksum 0x7D -> both writes occur; `err`=1; `core_rst_n` stays 0; `rx_ready`=0 afterwards.
- Header N=0x2001 -> `err`=1 after the 4th header byte; no `imem_we` ever.
- N=0, checksum 0x00 -> RUN with `word_cnt`=0. A randomly gapped `rx_valid` during an N=3 load gives identical writes.
- `reset` pulsed low after 2 data bytes -> all outputs return to reset values. A full reload then writes from word 0x2000 again.
